// File: rtl/spart_key_rx.sv
// Serial keyboard front end: 8N1 UART receiver that turns a fixed set of ASCII
// keys into 4-bit key codes with a one-cycle write strobe for the CPU.
module spart_key_rx #(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       SPART_we,
   output logic [3:0] SPART_keys,
   output logic [7:0] rx_byte,
   output logic       rx_byte_vld,
   output logic       frame_err
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   // Case-insensitive key lookup: {hit, code}
   function automatic logic [4:0] key_decode(input logic [7:0] b);
      logic [7:0] u;
      u = (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
      case (u)
         8'h57:   return 5'h11;  // W
         8'h41:   return 5'h12;  // A
         8'h53:   return 5'h13;  // S
         8'h44:   return 5'h14;  // D
         8'h51:   return 5'h15;  // Q
         8'h45:   return 5'h16;  // E
         8'h20:   return 5'h17;  // space
         8'h52:   return 5'h18;  // R
         8'h2B:   return 5'h19;  // +
         8'h2D:   return 5'h1A;  // -
         8'h0D:   return 5'h1B;  // Enter
         default: return 5'h00;
      endcase
   endfunction

   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state;
   logic [CW-1:0]          r_baud;
   logic [2:0]             r_bit_idx;
   logic [7:0]             r_shift;
   logic                   r_we;
   logic [3:0]             r_keys;
   logic [7:0]             r_byte;
   logic                   r_vld;
   logic                   r_ferr;

   logic                   w_rx_s;
   logic [4:0]             w_dec;

   assign w_rx_s = r_sync[SYNC_STAGES-1];
   assign w_dec  = key_decode(r_shift);

   // Input synchronizer, resets to the idle-high line level
   always_ff @(posedge clk) begin
      if (rst) r_sync <= '1;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
   end

   // Receive FSM; sample points are mid-bit and reload the baud counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_we      <= 1'b0;
         r_keys    <= 4'h0;
         r_byte    <= 8'h00;
         r_vld     <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_vld  <= 1'b0;
         r_ferr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_baud  <= '0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (r_baud == HALF_LAST) begin
                  r_baud <= '0;
                  if (!w_rx_s) begin
                     r_bit_idx <= '0;
                     r_state   <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
            S_DATA: begin
               if (r_baud == BIT_LAST) begin
                  r_baud             <= '0;
                  r_shift[r_bit_idx] <= w_rx_s;
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
                  else                   r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
            S_STOP: begin
               if (r_baud == BIT_LAST) begin
                  r_baud <= '0;
                  if (w_rx_s) begin
                     r_byte  <= r_shift;
                     r_vld   <= 1'b1;
                     r_state <= S_IDLE;
                     if (w_dec[4]) begin
                        r_we   <= 1'b1;
                        r_keys <= w_dec[3:0];
                     end
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= S_WAIT_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
            // Hold off through a break so it cannot look like a new start bit
            S_WAIT_IDLE: begin
               if (w_rx_s) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign SPART_we    = r_we;
   assign SPART_keys  = r_keys;
   assign rx_byte     = r_byte;
   assign rx_byte_vld = r_vld;
   assign frame_err   = r_ferr;

endmodule

// File: tb/tb_spart_key_rx.sv
// Scoreboard bench for spart_key_rx: a UART driver pushes expected responses
// from a key-table model; a negedge monitor pops and checks each output pulse.
module tb_spart_key_rx;

   localparam int unsigned BIT  = 217;
   localparam int unsigned SYNC = 2;
   localparam int          LAT  = SYNC + BIT / 2 + 9 * BIT + 1;

   typedef struct {
      bit       ferr;
      bit [7:0] b;
      bit       we;
      bit [3:0] keys;
      int       t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       SPART_we;
   logic [3:0] SPART_keys;
   logic [7:0] rx_byte;
   logic       rx_byte_vld;
   logic       frame_err;

   exp_t       sb[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         cyc    = 0;
   int         n_pulse = 0;
   bit         prev_pulse = 1'b0;
   bit [3:0]   model_keys = 4'h0;

   byte unsigned keymap [11] = '{8'h57, 8'h41, 8'h53, 8'h44, 8'h51, 8'h45,
                                 8'h20, 8'h52, 8'h2B, 8'h2D, 8'h0D};

   spart_key_rx #(.CLKS_PER_BIT(BIT), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .SPART_we(SPART_we), .SPART_keys(SPART_keys),
      .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: table position gives the code; letters fold to upper case
   function automatic bit [4:0] ref_key(input bit [7:0] b);
      bit [7:0] u;
      u = b;
      if (b >= "a" && b <= "z") u = b - 8'd32;
      for (int i = 0; i < 11; i++)
         if (keymap[i] == u) return {1'b1, 4'(i + 1)};
      return 5'h00;
   endfunction

   task automatic bit_out(input bit v);
      rx = v;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   // abort_bit >= 0: assert rst halfway through that data bit instead of finishing
   task automatic send_frame(input bit [7:0] b, input bit stop, input int abort_bit);
      exp_t     e;
      bit [4:0] k;
      if (abort_bit < 0) begin
         e.t = cyc;
         e.b = b;
         e.ferr = !stop;
         e.we = 1'b0;
         if (stop) begin
            k = ref_key(b);
            if (k[4]) model_keys = k[3:0];
            e.we = k[4];
         end
         e.keys = model_keys;
         sb.push_back(e);
      end
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == abort_bit) begin
            repeat (BIT / 2) @(posedge clk);
            #1;
            rst = 1'b1;
            rx  = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            rst = 1'b0;
            model_keys = 4'h0;
            return;
         end
         bit_out(b[i]);
      end
      bit_out(stop);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every output pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      bit   pulse;
      pulse = SPART_we | rx_byte_vld | frame_err;
      if (pulse) begin
         n_pulse++;
         check("no_consecutive_pulse", !prev_pulse, int'(prev_pulse), 0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", 1'b0, {SPART_we, rx_byte_vld, frame_err}, 0);
         end else begin
            e = sb.pop_front();
            check("frame_err", frame_err == e.ferr, frame_err, e.ferr);
            check("rx_byte_vld", rx_byte_vld == !e.ferr, rx_byte_vld, !e.ferr);
            check("SPART_we", SPART_we == e.we, SPART_we, e.we);
            if (!e.ferr) check("rx_byte", rx_byte == e.b, rx_byte, e.b);
            check("SPART_keys", SPART_keys == e.keys, SPART_keys, e.keys);
            check("latency", (cyc - e.t >= LAT - 1) && (cyc - e.t <= LAT + 1),
                  cyc - e.t, LAT);
         end
      end
      prev_pulse = pulse;
   end

   initial begin
      bit [7:0] b;
      bit [4:0] k;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;

      idle(1000);
      check("reset_SPART_we", SPART_we == 1'b0, SPART_we, 0);
      check("reset_SPART_keys", SPART_keys == 4'h0, SPART_keys, 0);
      check("reset_rx_byte", rx_byte == 8'h00, rx_byte, 0);
      check("reset_rx_byte_vld", rx_byte_vld == 1'b0, rx_byte_vld, 0);
      check("reset_frame_err", frame_err == 1'b0, frame_err, 0);
      check("reset_no_pulses", n_pulse == 0, n_pulse, 0);

      send_frame(8'h77, 1'b1, -1);
      idle(300);

      send_frame("D", 1'b1, -1);
      send_frame("x", 1'b1, -1);
      send_frame(" ", 1'b1, -1);
      idle(300);

      send_frame(8'h41, 1'b0, -1);
      bit_out(1'b0);
      bit_out(1'b0);
      bit_out(1'b0);
      idle(2 * BIT);
      send_frame("R", 1'b1, -1);
      idle(300);

      rx = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      idle(400);

      send_frame("q", 1'b1, 4);
      idle(300);
      send_frame("e", 1'b1, -1);
      idle(300);

      for (int n = 0; n < 14; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            b = keymap[$urandom_range(0, 10)];
            if (b >= "A" && b <= "Z" && $urandom_range(0, 1) == 1) b = b + 8'd32;
         end else begin
            b = 8'($urandom);
         end
         k = ref_key(b);
         send_frame(b, 1'b1, -1);
         if (k[4] == 1'b0 || $urandom_range(0, 2) != 0) idle($urandom_range(0, 300));
      end

      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
      idle(10);
      check("scoreboard_drained", sb.size() == 0, sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
